// File: rtl/wallace_multiplier_pipe.sv
// Pipelined Baugh-Wooley / Wallace-tree multiplier, unsigned or signed per transaction.
// CSA levels are split evenly across STAGES-1 internal registers; the CPA feeds the ans register.
module wallace_multiplier_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] ans
);
  localparam int P  = 2 * WIDTH;
  localparam int R0 = WIDTH + 1;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [R0-1:0][P-1:0] rows_t;

  function automatic int rows_after(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int count_levels();
    int n;
    int l;
    n = R0;
    l = 0;
    while (n > 2) begin
      n = rows_after(n);
      l++;
    end
    return l;
  endfunction

  localparam int L = count_levels();

  // Level boundary at which stage register s sits; boundary 0 is the raw partial products.
  function automatic int bnd(input int s);
    return (s * L) / STAGES;
  endfunction

  function automatic rows_t reduce(input rows_t r, input int from_lvl, input int to_lvl);
    rows_t cur;
    rows_t nxt;
    int    n;
    cur = r;
    n   = R0;
    for (int l = 0; l < L; l++) begin
      nxt = '0;
      for (int k = 0; k < R0 / 3; k++) begin
        if (k < n / 3) begin
          nxt[2*k]   = cur[3*k] ^ cur[3*k+1] ^ cur[3*k+2];
          nxt[2*k+1] = ((cur[3*k] & cur[3*k+1]) | (cur[3*k] & cur[3*k+2]) |
                        (cur[3*k+1] & cur[3*k+2])) << 1;
        end
      end
      for (int r2 = 0; r2 < 2; r2++) begin
        if (r2 < n % 3) nxt[2*(n/3)+r2] = cur[3*(n/3)+r2];
      end
      if (l >= from_lvl && l < to_lvl) cur = nxt;
      n = rows_after(n);
    end
    return cur;
  endfunction

  function automatic logic [P-1:0] cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  rows_t          pp;
  rows_t          rows_q [NR];
  rows_t          seg_in [STAGES];
  rows_t          seg_out [STAGES];
  logic [NR-1:0]  vld_q;
  logic [NR-1:0]  vld_d;
  logic           fin_vld;
  logic [P-1:0]   sum_d;
  logic [P-1:0]   ans_q;
  logic           out_valid_q;
  logic           stall;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign ans       = ans_q;

  // Sign-row terms (exactly one index at the MSB) are inverted; correction bits at WIDTH and P-1.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (A[j] & B[i]) ^ (tc & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    if (tc) begin
      pp[WIDTH][WIDTH] = 1'b1;
      pp[WIDTH][P-1]   = 1'b1;
    end
  end

  always_comb begin
    seg_in[0] = pp;
    for (int s = 1; s < STAGES; s++) begin
      seg_in[s] = rows_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      seg_out[s] = reduce(seg_in[s], bnd(s), bnd(s + 1));
    end
    sum_d = cpa(seg_out[STAGES-1]);
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int s = 1; s < NR; s++) begin
      vld_d[s] = vld_q[s-1];
    end
    fin_vld = (STAGES == 1) ? in_valid : vld_q[NR-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      ans_q       <= '0;
    end else if (!stall) begin
      for (int s = 0; s < STAGES - 1; s++) begin
        rows_q[s] <= seg_out[s];
      end
      vld_q       <= vld_d;
      out_valid_q <= fin_vld;
      if (fin_vld) ans_q <= sum_d;
    end
  end

endmodule

// File: tb/tb_wallace_multiplier_pipe.sv
// Bench for wallace_multiplier_pipe: directed tables on an 8x8/2-stage instance, exhaustive 4x4/1-stage,
// and a randomized WIDTH x STAGES sweep scored against a plain-arithmetic reference multiply.
module tb_wallace_multiplier_pipe;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        t;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   errors  = 0;
  int   checks  = 0;
  int   sw_done = 0;
  logic sweep_go;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic t);
    longint      av;
    longint      bv;
    longint      p;
    logic [63:0] m;
    av = longint'(a);
    bv = longint'(b);
    if (t && a[w-1]) av = av - (longint'(1) << w);
    if (t && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    m = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(p) & m;
  endfunction

  logic        rst_n, in_valid, in_ready, tc, out_valid, out_ready;
  logic [7:0]  a8, b8;
  logic [15:0] ans8;

  wallace_multiplier_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a8), .B(b8), .tc(tc),
    .out_valid(out_valid), .out_ready(out_ready), .ans(ans8));

  logic       x_iv, x_ir, x_t, x_ov, x_or;
  logic [3:0] x_a, x_b;
  logic [7:0] x_ans;

  wallace_multiplier_pipe #(.WIDTH(4), .STAGES(1)) ux (
    .clk(clk), .rst_n(rst_n), .in_valid(x_iv), .in_ready(x_ir), .A(x_a), .B(x_b), .tc(x_t),
    .out_valid(x_ov), .out_ready(x_or), .ans(x_ans));

  vec_t vq[$];

  // Back-to-back stream with out_ready=1: item k must show up in cycle k+2.
  task automatic run_stream();
    int n;
    n = vq.size();
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (k < n) begin
        in_valid = 1'b1;
        a8 = vq[k].a;
        b8 = vq[k].b;
        tc = vq[k].t;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream in_ready", in_ready, 1);
      if (k >= 2) begin
        chk($sformatf("stream valid[%0d]", k - 2), out_valid, 1);
        chk($sformatf("stream ans[%0d]", k - 2), ans8, vq[k-2].exp);
      end else begin
        chk("stream lead valid", out_valid, 0);
      end
    end
  endtask

  initial begin
    vec_t tbl[12];
    vec_t bq[6];
    vec_t v;
    int   idx, got, first_ov, last_pop, bound;
    logic [3:0] pa, pb;
    logic       pt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tc = 1'b0; a8 = '0; b8 = '0;
    x_iv = 1'b0; x_or = 1'b1; x_t = 1'b0; x_a = '0; x_b = '0;
    sweep_go = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset ans", ans8, 0);
    chk("reset in_ready", in_ready, 1);

    tbl[0]  = '{8'h0A, 8'h0A, 1'b0, 16'h0064};
    tbl[1]  = '{8'h00, 8'h03, 1'b0, 16'h0000};
    tbl[2]  = '{8'hFF, 8'h00, 1'b0, 16'h0000};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[4]  = '{8'hAA, 8'h0A, 1'b0, 16'h06A4};
    tbl[5]  = '{8'h0A, 8'h8B, 1'b0, 16'h056E};
    tbl[6]  = '{8'h3A, 8'hCA, 1'b0, 16'h2DC4};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[8]  = '{8'hF8, 8'h0F, 1'b1, 16'hFF88};
    tbl[9]  = '{8'hF8, 8'h0F, 1'b0, 16'h0E88};
    tbl[10] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[11] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    foreach (tbl[i]) vq.push_back(tbl[i]);
    for (int i = 0; i < 12; i++) begin
      v.a   = 8'($urandom);
      v.b   = 8'($urandom);
      v.t   = 1'(i % 2);
      v.exp = 16'(ref_mul(8, 32'(v.a), 32'(v.b), v.t));
      vq.push_back(v);
    end
    run_stream();

    // Backpressure: six transactions, out_ready low for 5 cycles from the first out_valid.
    for (int i = 0; i < 6; i++) begin
      bq[i].a   = 8'($urandom);
      bq[i].b   = 8'($urandom);
      bq[i].t   = 1'($urandom_range(0, 1));
      bq[i].exp = 16'(ref_mul(8, 32'(bq[i].a), 32'(bq[i].b), bq[i].t));
    end
    idx = 0; got = 0; first_ov = -1; last_pop = -1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (first_ov < 0 && out_valid) first_ov = cyc;
      out_ready = !(first_ov >= 0 && cyc < first_ov + 5);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        a8 = bq[idx].a; b8 = bq[idx].b; tc = bq[idx].t;
      end
      #1;
      if (!out_ready) begin
        chk("bp in_ready low", in_ready, 0);
        chk("bp out_valid held", out_valid, 1);
        chk("bp ans held", ans8, bq[0].exp);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp ans[%0d]", got), ans8, bq[got].exp);
        if (got == 0) chk("bp release cycle", cyc, first_ov + 5);
        else chk($sformatf("bp rate[%0d]", got), cyc, last_pop + 1);
        last_pop = cyc;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp delivered", got, 6);

    // Reset with three transactions in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; tc = 1'b0;
      a8 = 8'($urandom_range(1, 255)); b8 = 8'($urandom_range(1, 255));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst ans", ans8, 0);
    chk("rst in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("rst no stale", out_valid, 0);
    end

    // Exhaustive 4x4, one-stage: pair k shows up in cycle k+1.
    pa = '0; pb = '0; pt = 1'b0;
    for (int k = 0; k <= 512; k++) begin
      @(negedge clk);
      x_or = 1'b1;
      x_iv = (k < 512);
      x_a  = 4'(k);
      x_b  = 4'(k >> 4);
      x_t  = 1'(k >> 8);
      #1;
      if (k > 0) begin
        chk("exh valid", x_ov, 1);
        chk($sformatf("exh %0h*%0h tc=%0d", pa, pb, pt), x_ans, 8'(ref_mul(4, 32'(pa), 32'(pb), pt)));
      end
      pa = x_a; pb = x_b; pt = x_t;
    end
    x_iv = 1'b0;

    sweep_go = 1'b1;
    bound = 0;
    while (sw_done < 12 && bound < 5000) begin
      @(negedge clk);
      bound++;
    end
    chk("sweep completed", sw_done, 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    for (genvar si = 0; si < 3; si++) begin : g_s
      localparam int W = (wi == 0) ? 4 : (wi == 1) ? 8 : (wi == 2) ? 16 : 32;
      localparam int S = (si == 0) ? 1 : (si == 1) ? 2 : 4;

      logic           s_iv, s_ir, s_t, s_ov, s_or;
      logic [W-1:0]   s_a, s_b;
      logic [2*W-1:0] s_ans;

      wallace_multiplier_pipe #(.WIDTH(W), .STAGES(S)) u (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .A(s_a), .B(s_b), .tc(s_t),
        .out_valid(s_ov), .out_ready(s_or), .ans(s_ans));

      initial begin
        logic [63:0]    eq[$];
        int             acc_q[$];
        int             sc_q[$];
        int             stalls;
        int             acc, sc;
        logic           prev_stall;
        logic [2*W-1:0] prev_ans;
        string          tag;

        s_iv = 1'b0; s_or = 1'b1; s_t = 1'b0; s_a = '0; s_b = '0;
        stalls = 0; prev_stall = 1'b0; prev_ans = '0;
        tag = $sformatf("sweep W%0d S%0d", W, S);
        wait (sweep_go);
        for (int cyc = 0; cyc < 400 + S + 6; cyc++) begin
          @(negedge clk);
          s_iv = (cyc < 400) && ($urandom_range(0, 3) != 0);
          s_or = (cyc >= 400) || ($urandom_range(0, 3) != 0);
          s_a  = W'($urandom);
          s_b  = W'($urandom);
          s_t  = 1'($urandom_range(0, 1));
          #1;
          if (prev_stall) begin
            chk({tag, " hold valid"}, s_ov, 1);
            chk({tag, " hold ans"}, s_ans, prev_ans);
          end
          if (s_ov && s_or) begin
            if (eq.size() == 0) begin
              chk({tag, " spurious"}, s_ov, 0);
            end else begin
              acc = acc_q.pop_front();
              sc  = sc_q.pop_front();
              chk({tag, " ans"}, 64'(s_ans), eq.pop_front());
              chk({tag, " latency"}, cyc - acc, S + stalls - sc);
            end
          end
          if (s_iv && s_ir) begin
            eq.push_back(ref_mul(W, 32'(s_a), 32'(s_b), s_t));
            acc_q.push_back(cyc);
            sc_q.push_back(stalls);
          end
          prev_stall = s_ov && !s_or;
          prev_ans   = s_ans;
          if (prev_stall) stalls++;
        end
        s_iv = 1'b0;
        chk({tag, " drained"}, eq.size(), 0);
        sw_done++;
      end
    end
  end

endmodule
